// File: rtl/async_evt_pkg.sv
// Shared helpers for the asynchronous event arbiter: index width, round-robin pick and
// the minimum blanking length.
package async_evt_pkg;

  localparam int unsigned BlankMin = 3;
  localparam int unsigned MaxLines = 16;

  function automatic int unsigned id_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit at or after ptr, wrapping at n-1; returns 0 when nothing is pending.
  function automatic logic [3:0] rr_pick(logic [MaxLines-1:0] pending, logic [3:0] ptr,
                                         int unsigned n);
    logic [3:0]  sel;
    logic        found;
    int unsigned idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MaxLines; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !found && pending[idx[3:0]]) begin
        sel   = idx[3:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/synch_3.sv
// Three-stage synchronizer with registered edge detect; stages are intentionally unreset.
module synch_3 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] s1_q, s2_q, s3_q, prev_q;

  always_ff @(posedge clk) begin
    s1_q   <= d;
    s2_q   <= s1_q;
    s3_q   <= s2_q;
    prev_q <= s3_q;
  end

  assign o    = s3_q;
  assign rise = s3_q & ~prev_q;
  assign fall = ~s3_q & prev_q;

endmodule

// File: rtl/async_event_arbiter.sv
// Synchronizes N asynchronous event lines, latches their rising edges and serves them
// round-robin through a single valid/ready event port.
module async_event_arbiter
  import async_evt_pkg::*;
#(
  parameter int unsigned N            = 4,
  parameter int unsigned BLANK_CYCLES = 4,
  localparam int unsigned ID_W        = id_width(N)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    async_in,
  input  logic [N-1:0]    line_en,
  output logic [N-1:0]    sync_level,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  input  logic            evt_ready,
  output logic [N-1:0]    overflow,
  input  logic [N-1:0]    overflow_clr,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(BLANK_CYCLES + 1);

  logic [N-1:0]    rise;
  logic [N-1:0]    fall_unused;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    overflow_q, overflow_d;
  logic [N-1:0]    set, drop, load_mask;
  logic            valid_q, valid_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] sel;
  logic [CntW-1:0] blank_q, blank_d;
  logic            blanking;
  logic            load;

  for (genvar i = 0; i < N; i++) begin : g_sync
    synch_3 #(
      .WIDTH(1)
    ) u_sync (
      .clk  (clk),
      .d    (async_in[i]),
      .o    (sync_level[i]),
      .rise (rise[i]),
      .fall (fall_unused[i])
    );
  end

  always_comb begin
    blanking  = (blank_q != '0);
    blank_d   = blanking ? blank_q - 1'b1 : blank_q;
    set       = rise & line_en & {N{~blanking}};
    load      = (|pending_q) & (~valid_q | evt_ready);
    sel       = ID_W'(rr_pick(MaxLines'(pending_q), 4'(ptr_q), N));
    load_mask = load ? (N'(1) << sel) : '0;
    // A rise on the line being handed out this cycle refills pending instead of dropping.
    drop       = set & pending_q & ~load_mask;
    pending_d  = (pending_q & ~load_mask) | set;
    overflow_d = (overflow_q & ~overflow_clr) | drop;
    valid_d    = valid_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    if (load) begin
      valid_d = 1'b1;
      id_d    = sel;
      ptr_d   = (sel == ID_W'(N - 1)) ? '0 : sel + 1'b1;
    end else if (valid_q && evt_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_q  <= '0;
      overflow_q <= '0;
      valid_q    <= 1'b0;
      id_q       <= '0;
      ptr_q      <= '0;
      blank_q    <= CntW'(BLANK_CYCLES);
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      blank_q    <= blank_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_id    = id_q;
  assign overflow  = overflow_q;
  assign busy      = (|pending_q) | valid_q;

endmodule

// File: tb/tb_async_event_arbiter.sv
// Directed scenarios plus randomized traffic against a cycle-level event model.
module tb_async_event_arbiter;

  localparam int N     = 4;
  localparam int BLANK = 4;
  localparam int IDW   = 2;
  localparam int MAXE  = 8192;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   async_in;
  logic [N-1:0]   line_en;
  logic [N-1:0]   sync_level;
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_ready;
  logic [N-1:0]   overflow;
  logic [N-1:0]   overflow_clr;
  logic           busy;

  int checks = 0;
  int errors = 0;

  // Reference model: a record of sampled inputs plus the abstract arbiter state.
  logic [N-1:0] samp [0:MAXE-1];
  int           edge_cnt = 0;
  bit           m_valid;
  int           m_id;
  bit [N-1:0]   m_pend;
  bit [N-1:0]   m_ovf;
  int           m_ptr;
  int           m_blank;

  always #5 clk = ~clk;

  async_event_arbiter #(
    .N           (N),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .async_in     (async_in),
    .line_en      (line_en),
    .sync_level   (sync_level),
    .evt_valid    (evt_valid),
    .evt_id       (evt_id),
    .evt_ready    (evt_ready),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .busy         (busy)
  );

  task automatic model_step();
    bit [N-1:0] rise, set, drop, older;
    int pick;
    if (edge_cnt < MAXE) samp[edge_cnt] = async_in;
    rise = '0;
    // A rise reaches the arbiter three edges after the input was first sampled high.
    if (edge_cnt >= 3 && edge_cnt < MAXE) begin
      older = (edge_cnt >= 4) ? samp[edge_cnt-4] : '0;
      rise  = samp[edge_cnt-3] & ~older;
    end
    if (!reset_n) begin
      m_valid = 0; m_id = 0; m_pend = '0; m_ovf = '0; m_ptr = 0; m_blank = BLANK;
    end else begin
      set  = (m_blank != 0) ? '0 : (rise & line_en);
      pick = -1;
      if (m_pend != '0 && (!m_valid || evt_ready)) begin
        for (int k = 0; k < N; k++)
          if (pick < 0 && m_pend[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
      end
      drop = set & m_pend;
      if (pick >= 0) begin
        drop[pick]   = 1'b0;
        m_pend[pick] = 1'b0;
        m_valid      = 1;
        m_id         = pick;
        m_ptr        = (pick + 1) % N;
      end else if (m_valid && evt_ready) begin
        m_valid = 0;
      end
      m_pend = m_pend | set;
      m_ovf  = (m_ovf & ~overflow_clr) | drop;
      if (m_blank > 0) m_blank--;
    end
    edge_cnt++;
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; async_in = '1; line_en = '1; evt_ready = 1'b1; overflow_clr = '0;
    tick(2);
    checks++;
    if (evt_valid !== 1'b0 || overflow !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b overflow=%b busy=%b, required 0 0000 0",
               evt_valid, overflow, busy);
    end
    reset_n = 1'b1;
    for (int c = 0; c < BLANK + 4; c++) begin
      tick(1);
      checks++;
      if (evt_valid !== 1'b0 || overflow !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL blank_window c%0d: valid=%b overflow=%b busy=%b, required 0 0000 0",
                 c, evt_valid, overflow, busy);
      end
    end
    checks++;
    if (sync_level !== 4'b1111) begin
      errors++;
      $display("FAIL sync_level_preload: got %b, required 1111", sync_level);
    end
    async_in = '0;
    tick(5);
  endtask

  task automatic test_single();
    async_in = 4'b0100; evt_ready = 1'b1;
    tick(3);
    checks++;
    if (sync_level !== 4'b0100) begin
      errors++; $display("FAIL single_sync_E2: got %b, required 0100", sync_level);
    end
    tick(1);
    checks++;
    if (evt_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_E3: valid=%b busy=%b, required 0 1", evt_valid, busy);
    end
    tick(1);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd2 || overflow !== 4'b0000) begin
      errors++;
      $display("FAIL single_E4: valid=%b id=%0d overflow=%b, required 1 2 0000",
               evt_valid, evt_id, overflow);
    end
    tick(1);
    checks++;
    if (evt_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_E5: valid=%b busy=%b, required 0 0", evt_valid, busy);
    end
    async_in = '0;
    tick(4);
  endtask

  task automatic test_round_robin();
    int exp_ids [3] = '{0, 1, 3};
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(6);
    async_in = 4'b1011;
    tick(4);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== exp_ids[k][IDW-1:0]) begin
        errors++;
        $display("FAIL rr_burst k%0d: valid=%b id=%0d, required 1 %0d",
                 k, evt_valid, evt_id, exp_ids[k]);
      end
    end
    tick(1);
    checks++;
    if (evt_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rr_drain: valid=%b busy=%b, required 0 0", evt_valid, busy);
    end
    async_in = '0;
    tick(4);
    // Pointer wrapped to 0 after id 3, so line 0 must precede line 3.
    async_in = 4'b1001;
    tick(5);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
      errors++; $display("FAIL rr_wrap_first: valid=%b id=%0d, required 1 0", evt_valid, evt_id);
    end
    tick(1);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin
      errors++; $display("FAIL rr_wrap_second: valid=%b id=%0d, required 1 3", evt_valid, evt_id);
    end
    async_in = '0;
    tick(5);
  endtask

  task automatic test_overflow();
    bit pat [12] = '{0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    evt_ready = 1'b0; async_in = 4'b0010;
    tick(5);
    for (int k = 0; k < 12; k++) begin
      async_in[1] = pat[k];
      tick(1);
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
        errors++;
        $display("FAIL ovf_hold k%0d: valid=%b id=%0d, required 1 1", k, evt_valid, evt_id);
      end
    end
    checks++;
    if (overflow !== 4'b0010 || busy !== 1'b1) begin
      errors++; $display("FAIL ovf_flag: overflow=%b busy=%b, required 0010 1", overflow, busy);
    end
    evt_ready = 1'b1;
    tick(1);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
      errors++; $display("FAIL ovf_second: valid=%b id=%0d, required 1 1", evt_valid, evt_id);
    end
    tick(1);
    checks++;
    if (evt_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ovf_only_one: valid=%b busy=%b, required 0 0", evt_valid, busy);
    end
    overflow_clr = 4'b0010;
    tick(1);
    overflow_clr = '0;
    checks++;
    if (overflow !== 4'b0000) begin
      errors++; $display("FAIL ovf_clear: overflow=%b, required 0000", overflow);
    end
    async_in = '0;
    tick(4);
  endtask

  task automatic test_line_en();
    line_en = 4'b1110; async_in = 4'b0001;
    tick(3);
    checks++;
    if (sync_level[0] !== 1'b1) begin
      errors++; $display("FAIL en_sync_level: got %b, required 1", sync_level[0]);
    end
    tick(4);
    checks++;
    if (evt_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL en_disabled: valid=%b busy=%b, required 0 0", evt_valid, busy);
    end
    line_en = '1; async_in = '0;
    tick(2);
    async_in = 4'b0001;
    tick(5);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
      errors++; $display("FAIL en_enabled: valid=%b id=%0d, required 1 0", evt_valid, evt_id);
    end
    tick(1);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL en_single: valid=%b, required 0", evt_valid);
    end
    async_in = '0;
    tick(4);
  endtask

  task automatic test_reset_mid();
    evt_ready = 1'b0; async_in = 4'b0001;
    tick(5);
    async_in = 4'b0111;
    tick(2);
    async_in = 4'b0011;
    tick(2);
    async_in = 4'b0111;
    tick(5);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0 || overflow !== 4'b0100 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: valid=%b id=%0d overflow=%b busy=%b, required 1 0 0100 1",
               evt_valid, evt_id, overflow, busy);
    end
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    checks++;
    if (evt_valid !== 1'b0 || overflow !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b overflow=%b busy=%b, required 0 0000 0",
               evt_valid, overflow, busy);
    end
    evt_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      checks++;
      if (evt_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_quiet c%0d: valid=%b busy=%b, required 0 0", c, evt_valid, busy);
      end
    end
    async_in = '0;
    tick(5);
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) async_in[b] = ~async_in[b];
      if ($urandom_range(15) == 0) line_en = N'($urandom);
      evt_ready    = ($urandom_range(3) != 0);
      overflow_clr = ($urandom_range(7) == 0) ? N'($urandom) : '0;
      reset_n      = ($urandom_range(599) != 0);
      tick(1);
      checks++;
      if (evt_valid !== m_valid || (m_valid && evt_id !== m_id[IDW-1:0])) begin
        errors++;
        $display("FAIL rand_event c%0d: valid=%b id=%0d, required %0b %0d",
                 c, evt_valid, evt_id, m_valid, m_id);
      end
      checks++;
      if (overflow !== m_ovf) begin
        errors++; $display("FAIL rand_overflow c%0d: got %b, required %b", c, overflow, m_ovf);
      end
      checks++;
      if (busy !== (m_valid || m_pend != '0)) begin
        errors++;
        $display("FAIL rand_busy c%0d: got %b, required %b", c, busy, m_valid || m_pend != '0);
      end
      checks++;
      if (sync_level !== samp[edge_cnt-3]) begin
        errors++;
        $display("FAIL rand_sync c%0d: got %b, required %b", c, sync_level, samp[edge_cnt-3]);
      end
    end
    reset_n = 1'b1; overflow_clr = '0;
  endtask

  initial begin
    reset_n = 1'b0; async_in = '1; line_en = '1; evt_ready = 1'b1; overflow_clr = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_line_en();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_event_arbiter.md
Name: async_event_arbiter

Overview:
Conditions N asynchronous single-bit event lines (buttons, bridge strobes, host flags) for the core clock domain. Each line passes through its own 3-stage synchronizer with edge detection. Rising edges are latched as pending events, and a round-robin scheduler shares one valid/ready event port between all lines. It sits between the platform's asynchronous inputs and the core's single event consumer (command decoder / interrupt sequencer).

Parameters:
N, 4, number of asynchronous input lines; legal range 2..16.
BLANK_CYCLES, 4, cycles after reset release during which detected edges are discarded; must be at least 3.
ID_W, $clog2(N), width of the event index; derived, never overridden.

Ports:
clk  input  1  core clock; all logic on posedge.
reset_n  input  1  synchronous, active-low reset.
async_in  input  N  asynchronous event lines; one synchronizer per bit.
line_en  input  N  per-line enable; a rise on a disabled line is ignored.
sync_level  output  N  synchronized level of each line (synchronizer output).
evt_valid  output  1  an event is presented on evt_id.
evt_id  output  ID_W  index of the line whose rise is presented.
evt_ready  input  1  consumer accepts the event when evt_valid && evt_ready.
overflow  output  N  sticky per-line flag: a rise was dropped.
overflow_clr  input  N  per-bit clear of overflow.
busy  output  1  high when any pending bit is set or evt_valid is high.

Behaviour:
- Reset (reset_n=0 at a clk edge): pending=0, evt_valid=0, evt_id=0, rr_ptr=0, overflow=0, blank counter loaded with BLANK_CYCLES. Synchronizer stages are not reset. sync_level is an unreset pass-through. Any held or pending event is discarded.
- Blanking: while blank counter != 0 it decrements each cycle and all rise pulses are ignored. This suppresses spurious edges from unreset synchronizer contents.
- Edge capture, per line i:
  - set_i = rise_i & line_en[i] & ~blanking.
  - If set_i and pending[i]=0, set pending[i].
  - If set_i, pending[i]=1, and line i is not being loaded this cycle, the event is dropped and overflow[i] is set.
  - If set_i coincides with pending[i] being cleared by a load, pending[i] stays 1 (new event) and there is no overflow.
- Output register:
  - load = |pending & (~evt_valid | evt_ready).
  - On load: evt_id = selected index, evt_valid=1, pending[sel] cleared, rr_ptr = sel+1 modulo N.
  - If evt_valid && evt_ready and no load occurs, evt_valid goes to 0.
  - evt_id is held stable while evt_valid && !evt_ready.
- Round-robin selection: first set pending bit scanning rr_ptr, rr_ptr+1, ..., wrapping at N-1 to 0. Each line therefore waits at most N-1 grants.
- Back-to-back: with ready held high, one event issues per cycle with no bubble.
- Latency: input stable high before edge E0, then:
  - s1 loads at E0, s2 at E1, sync_level at E2.
  - rise is high in the cycle after E2.
  - pending is set at E3.
  - evt_valid is high after E4, with an idle output and no contention.
- Overflow: overflow_clr[i] clears bit i. A simultaneous set on the same bit wins (bit stays 1).
- busy = |pending | evt_valid.
- Falling edges are never queued. A pulse shorter than one clock period may be missed; this is a documented limitation, not an error.

Decomposition:
- Package async_evt_pkg holds: the ID_W derivation function, the round-robin next-index function (pending vector, pointer to index), and the BLANK_CYCLES minimum constant.
- Sub-module: the existing 1-bit synch_3 is instantiated N times (generate loop, WIDTH=1), using o and rise; fall is left unconnected.
- The round-robin picker stays a function in the package, not a separate module.

Test Plan:
1. Reset release with async_in=4'b1111 preloaded in the synchronizers -> no evt_valid, overflow=0 during and after BLANK_CYCLES=4.
2. Raise async_in[2] alone, evt_ready=1 -> evt_valid high for one cycle after E4 with evt_id=2; overflow=0; busy drops the next cycle.
3. Raise lines 0,1,3 in the same cycle, evt_ready=1, rr_ptr=0 -> events in consecutive cycles with ids 0,1,3; rr_ptr=0 after id 3.
4. evt_ready=0, raise line 1, then toggle line 1 low/high twice more -> evt_id=1 held stable; overflow[1]=1; after ready, exactly one more id=1 event issues (the second rise was kept in pending, the third dropped).
5. line_en[0]=0, raise line 0 -> no event; sync_level[0]=1 after E2; then set line_en=1, lower and raise line 0 -> one event id=0.
6. Assert reset_n=0 for one cycle while evt_valid=1 and pending=4'b0110 -> evt_valid=0, pending=0, overflow=0 on the next cycle; no event within 4 cycles after release.
